regbus_reg_bank: RTL
====================

// Module: regbus_reg_bank
// PURPOSE
// - Register-bank slave on the generic register bus, directly downstream of the APB3-to-regbus bridge.
// - Consumes one-cycle rstrobe/wstrobe pulses and returns rdata, rack/wack and raddrerr/waddrerr.
// - Holds CTRL, STATUS, interrupt and scratch registers.
// - A counter inserts a programmable acknowledge delay so bridge wait-state paths get exercised.
// PARAMETERS
// - ADDR_WIDTH   8   byte address width, >= 6 and large enough for the full map
// - DATA_WIDTH   32  register width; word stride = DATA_WIDTH/8 bytes
// - NUM_SCRATCH  4   number of RW scratch registers, 1..8
// - ACK_DELAY    0   extra wait cycles between strobe and ack, 0..15
// PORTS
// - clk          in   1            clock; all logic on rising edge
// - reset        in   1            asynchronous, active-high reset
// - rb_waddr     in   ADDR_WIDTH   write byte address
// - rb_raddr     in   ADDR_WIDTH   read byte address
// - rb_wdata     in   DATA_WIDTH   write data
// - rb_wstrobe   in   1            one-cycle write request
// - rb_rstrobe   in   1            one-cycle read request
// - rb_rdata     out  DATA_WIDTH   read data; valid with rb_rack, held until the next read strobe
// - rb_wack      out  1            one-cycle write acknowledge
// - rb_rack      out  1            one-cycle read acknowledge
// - rb_waddrerr  out  1            write decode error; asserted with wack, held until the next strobe
// - rb_raddrerr  out  1            read decode error; asserted with rack, held until the next strobe
// - status_in    in   DATA_WIDTH   live status, sampled on read
// - irq_src      in   DATA_WIDTH   per-bit interrupt set pulses
// - ctrl_out     out  DATA_WIDTH   CTRL register contents
// - irq          out  1            registered OR of (IRQ_STAT & IRQ_EN)
// BEHAVIOUR
// - Address map (offsets are word index * DATA_WIDTH/8):
//   - 0x00 CTRL, RW
//   - 0x04 STATUS, RO; writes are accepted and ignored, with no error
//   - 0x08 IRQ_STAT, W1C
//   - 0x0C IRQ_EN, RW
//   - 0x10 onward: SCRATCH[0..NUM_SCRATCH-1], RW
// - Decode error for any other address, or when addr[1:0] != 0.
//   - Errored write: no register changes.
//   - Errored read: rb_rdata = 0.
// - Reset values: all registers, rb_rdata, acks, errors, irq and ctrl_out are 0. FSM state is IDLE.
// - FSM states: IDLE, WAIT, ACK.
//   - IDLE: a strobe captures address, wdata and direction. Next state is WAIT with cnt=ACK_DELAY if ACK_DELAY>0, otherwise ACK.
//   - WAIT: cnt decrements each cycle; at 0 the next state is ACK.
//   - ACK: drive rack or wack for exactly one cycle, then return to IDLE.
// - Latency: strobe in cycle T gives ack in cycle T+1+ACK_DELAY.
// - Write timing: the register updates on the edge that enters ACK, so new data is readable from the ack cycle.
// - Read timing: data is sampled on the edge that enters ACK.
// - Errors: raddrerr/waddrerr rise with the ack and stay high until the next strobe. The bridge samples the error one cycle after the ack.
// - Strobe while not IDLE: ignored, no ack.
// - rstrobe and wstrobe asserted together: treated as protocol violation, the read is serviced and the write is dropped.
// - IRQ_STAT update: bit = (bit & ~w1c_mask) | irq_src.
//   - If set and clear hit the same bit in the same cycle, set wins.
// - irq is registered: it asserts one cycle after the IRQ_STAT or IRQ_EN change.
// - Reset asserted mid-access: the pending access is dropped, no ack is produced and all state returns to reset values.
// CONFIGURATION
// - REGBANK_IRQ_EN defined: IRQ_STAT, IRQ_EN and the irq output are implemented as above.
// - REGBANK_IRQ_EN undefined:
//   - 0x08 and 0x0C decode as errors.
//   - The SCRATCH offsets do not change.
//   - irq is tied to 0 and irq_src is ignored.
// TESTING
// - Write then read, ACK_DELAY=0: write CTRL=0xA5A5_0001 -> wack at T+1, ctrl_out=0xA5A5_0001. Read 0x00 -> rack at T+1, rdata=0xA5A5_0001, no error.
// - ACK_DELAY=3: read SCRATCH0 -> rack exactly at T+4. A second strobe issued at T+2 gets no ack.
// - Bad addresses: read 0x7C -> rack with raddrerr=1 and rdata=0. Write 0x02 -> wack with waddrerr=1, no register changes. Each error flag clears on the next strobe.
// - IRQ: set IRQ_EN=0x1 and pulse irq_src bit0 -> irq=1 one cycle later. W1C 0x1 while bit0 pulses in the same cycle -> bit stays set. A W1C alone -> irq=0.
// - Reset mid-access: ACK_DELAY=5, assert reset 2 cycles after a write strobe -> no wack, target register reads 0 after reset.
// - Build without REGBANK_IRQ_EN: read 0x08 -> raddrerr=1; irq stays 0 under irq_src=all-ones.

Source files
------------

// File: rtl/regbus_reg_bank_if.sv
// Generic register-bus interface between the APB3-to-regbus bridge (master)
// and a register-bank slave.
interface regbus_reg_bank_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] rb_waddr;
    logic [ADDR_WIDTH-1:0] rb_raddr;
    logic [DATA_WIDTH-1:0] rb_wdata;
    logic                  rb_wstrobe;
    logic                  rb_rstrobe;
    logic [DATA_WIDTH-1:0] rb_rdata;
    logic                  rb_wack;
    logic                  rb_rack;
    logic                  rb_waddrerr;
    logic                  rb_raddrerr;

    modport master (
        output rb_waddr, rb_raddr, rb_wdata, rb_wstrobe, rb_rstrobe,
        input  rb_rdata, rb_wack, rb_rack, rb_waddrerr, rb_raddrerr
    );

    modport slave (
        input  rb_waddr, rb_raddr, rb_wdata, rb_wstrobe, rb_rstrobe,
        output rb_rdata, rb_wack, rb_rack, rb_waddrerr, rb_raddrerr
    );
endinterface

// File: rtl/regbus_reg_bank.sv
// Register-bank slave on the generic register bus: CTRL, STATUS, optional
// interrupt registers and scratch registers, with a programmable ack delay.
// Build option: define REGBANK_IRQ_EN to implement IRQ_STAT/IRQ_EN and irq;
// otherwise 0x08/0x0C decode as errors and irq is tied low.
// Assumes DATA_WIDTH >= 32 (word stride of at least 4 bytes).
module regbus_reg_bank #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_SCRATCH = 4,
    parameter int unsigned ACK_DELAY   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    regbus_reg_bank_if.slave      rb,
    input  logic [DATA_WIDTH-1:0] status_in,
    input  logic [DATA_WIDTH-1:0] irq_src,
    output logic [DATA_WIDTH-1:0] ctrl_out,
    output logic                  irq
);
    localparam int unsigned OffW = (DATA_WIDTH / 8 > 4) ? $clog2(DATA_WIDTH / 8) : 2;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StAck  = 2'd2;

    localparam logic [3:0] DelayInit = 4'(ACK_DELAY);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  is_read_q, is_read_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  raddrerr_q, raddrerr_d;
    logic                  waddrerr_q, waddrerr_d;
    logic [DATA_WIDTH-1:0] scratch_q [NUM_SCRATCH];
    logic [DATA_WIDTH-1:0] scratch_d [NUM_SCRATCH];

    logic                   accept;
    logic                   enter_ack;
    logic                   acc_read;
    logic [ADDR_WIDTH-1:0]  acc_addr;
    logic [DATA_WIDTH-1:0]  acc_wdata;
    int unsigned            acc_idx;
    logic                   acc_hit;
    logic                   acc_err;
    logic [DATA_WIDTH-1:0]  rd_val;
    logic [NUM_SCRATCH-1:0] scratch_sel;
    logic                   do_write;

`ifdef REGBANK_IRQ_EN
    logic [DATA_WIDTH-1:0] irq_stat_q, irq_stat_d;
    logic [DATA_WIDTH-1:0] irq_en_q, irq_en_d;
    logic [DATA_WIDTH-1:0] w1c_mask;
    logic                  irq_q, irq_d;
`else
    logic unused_irq_src;
    assign unused_irq_src = ^irq_src;
`endif

    // Sequencing: capture the access in IDLE, count the delay, then ack once.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        enter_ack = 1'b0;
        accept    = (state_q == StIdle) && (rb.rb_rstrobe || rb.rb_wstrobe);
        // With no delay the access completes straight from IDLE, so use live bus values.
        acc_read  = (state_q == StIdle) ? rb.rb_rstrobe : is_read_q;
        acc_addr  = (state_q == StIdle) ? (rb.rb_rstrobe ? rb.rb_raddr : rb.rb_waddr) : addr_q;
        acc_wdata = (state_q == StIdle) ? rb.rb_wdata : wdata_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    is_read_d = acc_read;
                    addr_d    = acc_addr;
                    wdata_d   = acc_wdata;
                    if (ACK_DELAY > 0) begin
                        state_d = StWait;
                        cnt_d   = DelayInit;
                    end else begin
                        state_d   = StAck;
                        enter_ack = 1'b1;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = StAck;
                    enter_ack = 1'b1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Address decode and read mux for the access in flight.
    always_comb begin
        acc_idx     = 32'(acc_addr[ADDR_WIDTH-1:OffW]);
        acc_hit     = 1'b0;
        rd_val      = '0;
        scratch_sel = '0;
        if (acc_idx == 0) begin
            acc_hit = 1'b1;
            rd_val  = ctrl_q;
        end else if (acc_idx == 1) begin
            acc_hit = 1'b1;
            rd_val  = status_in;
`ifdef REGBANK_IRQ_EN
        end else if (acc_idx == 2) begin
            acc_hit = 1'b1;
            rd_val  = irq_stat_q;
        end else if (acc_idx == 3) begin
            acc_hit = 1'b1;
            rd_val  = irq_en_q;
`endif
        end else begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                if (acc_idx == 4 + i) begin
                    acc_hit        = 1'b1;
                    rd_val         = scratch_q[i];
                    scratch_sel[i] = 1'b1;
                end
            end
        end
        acc_err  = (|acc_addr[OffW-1:0]) || !acc_hit;
        do_write = enter_ack && !acc_read && !acc_err;
    end

    // Register, read-data and error-flag next state; all land on the edge entering ACK.
    always_comb begin
        ctrl_d     = ctrl_q;
        rdata_d    = rdata_q;
        raddrerr_d = raddrerr_q;
        waddrerr_d = waddrerr_q;
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
            scratch_d[i] = scratch_q[i];
            if (do_write && scratch_sel[i]) begin
                scratch_d[i] = acc_wdata;
            end
        end
        if (do_write && acc_idx == 0) begin
            ctrl_d = acc_wdata;
        end
        if (enter_ack && acc_read) begin
            rdata_d = acc_err ? '0 : rd_val;
        end
        if (accept) begin
            raddrerr_d = 1'b0;
            waddrerr_d = 1'b0;
        end
        if (enter_ack) begin
            if (acc_read) begin
                raddrerr_d = acc_err;
            end else begin
                waddrerr_d = acc_err;
            end
        end
    end

    // Bus-side and register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_read_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ctrl_q     <= '0;
            rdata_q    <= '0;
            raddrerr_q <= 1'b0;
            waddrerr_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_read_q  <= is_read_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ctrl_q     <= ctrl_d;
            rdata_q    <= rdata_d;
            raddrerr_q <= raddrerr_d;
            waddrerr_q <= waddrerr_d;
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= scratch_d[i];
            end
        end
    end

`ifdef REGBANK_IRQ_EN
    // Interrupt next state: a set pulse beats a same-cycle W1C; irq lags one cycle.
    always_comb begin
        w1c_mask   = (do_write && acc_idx == 2) ? acc_wdata : '0;
        irq_en_d   = (do_write && acc_idx == 3) ? acc_wdata : irq_en_q;
        irq_stat_d = (irq_stat_q & ~w1c_mask) | irq_src;
        irq_d      = |(irq_stat_q & irq_en_q);
    end

    // Interrupt state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_stat_q <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_stat_q <= irq_stat_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign rb.rb_rdata    = rdata_q;
    assign rb.rb_rack     = (state_q == StAck) && is_read_q;
    assign rb.rb_wack     = (state_q == StAck) && !is_read_q;
    assign rb.rb_raddrerr = raddrerr_q;
    assign rb.rb_waddrerr = waddrerr_q;
    assign ctrl_out       = ctrl_q;
endmodule
